// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, memory-stage FSM states and
// the writeback bundle also consumed by the writeback stage.
package pipeline_pkg;

  localparam int DATA_W     = 24;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                  regWe;
    logic [REG_ADDR_W-1:0] regToWrite;
    logic [DATA_W-1:0]     wbData;
  } wb_bundle_t;

  // All-zero bundle: a writeback bubble that writes nothing.
  localparam wb_bundle_t WB_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
//
// Handshake: the master raises memReq with memWrite/memAddr/memWdata valid and
// holds all of them stable until it samples memAck=1 on a rising edge; that
// edge completes the access (memRdata is valid in the same cycle as memAck for
// loads). memAck while memReq=0 carries no meaning and is ignored. A reset may
// drop memReq without an ack, which aborts the access.
interface memory_stage_if #(
  parameter int DATA_W = pipeline_pkg::DATA_W
) ();

  logic              memReq;
  logic              memWrite;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic              memAck;

  modport master (
    output memReq, memWrite, memAddr, memWdata,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWrite, memAddr, memWdata,
    output memRdata, memAck
  );

endinterface

// File: rtl/mem_wb_reg.sv
// Memory/writeback pipeline register. A bubble request loads an all-zero
// bundle so a stalled or failed access never reaches the register file.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble_i,
  input  wb_bundle_t d_i,
  output wb_bundle_t q_o
);

  wb_bundle_t q_q;

  // Register the writeback bundle every edge; bubble or reset forces zeros.
  always_ff @(posedge clk) begin
    if (reset || bubble_i) begin
      q_q <= WB_BUBBLE;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/memory_stage.sv
// Fourth pipeline stage: performs the data-memory access for loads/stores over
// a req/ack bus, stalls upstream until the access completes, and registers the
// writeback bundle for the decode-stage register file.
// Optional feature macro: MEM_STAGE_TIMEOUT_EN (bus-timeout counter, sticky
// memFault). Without it WAIT lasts until memAck and memFault is tied 0.
module memory_stage #(
  parameter int DATA_W         = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W     = pipeline_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memWeIn,
  input  logic                    regWeIn,
  input  logic                    writeRegFromAluIn,
  input  logic [REG_ADDR_W-1:0]   regToWriteIn,
  input  logic [DATA_W-1:0]       dataToWriteIn,
  input  logic [DATA_W-1:0]       resultIn,
  memory_stage_if.master          mem,
  output logic                    stall,
  output logic                    regWeOut,
  output logic [REG_ADDR_W-1:0]   regToWriteOut,
  output logic [DATA_W-1:0]       wbData,
  output logic                    memFault,
  output pipeline_pkg::mem_state_t state_dbg_o
);

  pipeline_pkg::mem_state_t state_q, state_d;
  pipeline_pkg::wb_bundle_t wb_d, wb_q;

  logic is_store;
  logic is_load;
  logic mem_op;
  logic timeout_hit;
  logic bubble;

  // Classify the instruction presented by execute.
  assign is_store = memWeIn;
  assign is_load  = regWeIn & ~writeRegFromAluIn & ~memWeIn;
  assign mem_op   = is_store | is_load;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;

  // Expiry only without an ack in the same cycle: a late ack still wins.
  assign timeout_hit = (state_q == pipeline_pkg::WAIT) && !mem.memAck &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counter held at zero outside WAIT so it starts from 0 on entry; saturates.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q | timeout_hit;
    if (state_q == pipeline_pkg::IDLE) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Wait counter and sticky fault flag; only reset clears the fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign memFault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign memFault    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= pipeline_pkg::IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter WAIT only when an access does not finish at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      pipeline_pkg::IDLE: if (mem_op && !mem.memAck) state_d = pipeline_pkg::WAIT;
      pipeline_pkg::WAIT: if (mem.memAck || timeout_hit) state_d = pipeline_pkg::IDLE;
      default:            state_d = pipeline_pkg::IDLE;
    endcase
  end

  // FSM outputs: request and stall, both forced low during reset.
  always_comb begin
    mem.memReq = 1'b0;
    stall      = 1'b0;
    if (!reset) begin
      case (state_q)
        pipeline_pkg::IDLE: begin
          mem.memReq = mem_op;
          stall      = mem_op & ~mem.memAck;
        end
        pipeline_pkg::WAIT: begin
          mem.memReq = 1'b1;
          stall      = ~mem.memAck & ~timeout_hit;
        end
        default: begin
          mem.memReq = 1'b0;
          stall      = 1'b0;
        end
      endcase
    end
  end

  // Bus fields follow the held upstream inputs; meaningful only with memReq.
  assign mem.memWrite = is_store;
  assign mem.memAddr  = resultIn;
  assign mem.memWdata = dataToWriteIn;

  // Writeback candidate: load data only for a load, ALU result otherwise.
  always_comb begin
    wb_d            = pipeline_pkg::WB_BUBBLE;
    wb_d.regWe      = regWeIn;
    wb_d.regToWrite = regToWriteIn;
    wb_d.wbData     = is_load ? mem.memRdata : resultIn;
  end

  // A stalled cycle or a timed-out access must not write back.
  assign bubble = stall | timeout_hit;

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (bubble),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  assign regWeOut      = wb_q.regWe;
  assign regToWriteOut = wb_q.regToWrite;
  assign wbData        = wb_q.wbData;
  assign state_dbg_o   = state_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Fourth pipeline stage. Sits between executionStage and the writeback stage.
- Consumes the execute outputs: memWe, regWe, writeRegFromAlu, regToWrite, dataToWrite and the ALU result.
- Performs the data-memory access over a req/ack bus. Stalls the pipeline until the access completes.
- Registers wbData, regToWrite and regWe for writeback. Those registered outputs drive the decode stage register-file write inputs (regWeIn, wbData, regToWriteIn).

Parameters:
- DATA_W, 24: datapath and memory word width.
- REG_ADDR_W, 4: register index width.
- TIMEOUT_CYCLES, 15: maximum wait cycles for memAck (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- memWeIn  in  1  store request from execute.
- regWeIn  in  1  register write enable from execute.
- writeRegFromAluIn  in  1  1 = writeback value is the ALU result; 0 = writeback value is the load data.
- regToWriteIn  in  REG_ADDR_W  destination register.
- dataToWriteIn  in  DATA_W  store data.
- resultIn  in  DATA_W  ALU result; this is the memory address for loads and stores.
- memReq  out  1  bus request.
- memWrite  out  1  1 = store, 0 = load; valid while memReq=1.
- memAddr  out  DATA_W  bus address.
- memWdata  out  DATA_W  bus write data.
- memRdata  in  DATA_W  load data; valid when memAck=1.
- memAck  in  1  bus completion.
- stall  out  1  upstream stages must hold their inputs.
- regWeOut  out  1  registered write enable to writeback.
- regToWriteOut  out  REG_ADDR_W  registered destination register.
- wbData  out  DATA_W  registered writeback data.
- memFault  out  1  sticky bus-timeout flag.

Behaviour:
- Operation classification (combinational, from inputs):
  - isStore = memWeIn.
  - isLoad = regWeIn & ~writeRegFromAluIn & ~memWeIn.
  - memOp = isStore | isLoad.
- FSM states: IDLE, WAIT.
  - IDLE, memOp=1: memReq=1 in the same cycle. memAddr=resultIn, memWrite=isStore, memWdata=dataToWriteIn.
  - IDLE, memAck=1 in that same cycle: zero-wait completion; stay IDLE, stall=0.
  - IDLE, memAck=0: go to WAIT, stall=1.
  - WAIT: memReq stays 1 with the same bus fields; upstream holds its inputs stable while stall=1. stall = ~memAck.
  - WAIT, memAck=1: return to IDLE, stall=0 in that cycle.
  - memReq=0 and stall=0 whenever memOp=0.
- Output register, updated every edge:
  - Completing cycle (stall=0): load real values.
    - regWeOut = regWeIn.
    - regToWriteOut = regToWriteIn.
    - wbData = writeRegFromAluIn ? resultIn : memRdata (memRdata only for a load).
    - For a store, regWeOut = regWeIn (0 in normal code) and wbData = resultIn.
  - Cycle with stall=1: load a bubble (regWeOut=0, regToWriteOut=0, wbData=0), so writeback is never repeated or premature.
- Latency:
  - ALU op and zero-wait memory: 1 cycle, input to registered output.
  - Load with N wait cycles: N+1 cycles.
- Reset:
  - Reset values: state=IDLE, regWeOut=0, regToWriteOut=0, wbData=0, memFault=0.
  - Combinational outputs memReq and stall are 0 in a reset cycle.
  - Reset asserted during WAIT aborts the access. The bus may see memReq drop without ack; the bus must tolerate this.
- Simultaneous events: an ack arriving in the same cycle as a timeout expiry counts as a success.
- memAck while memReq=0: ignored.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without memAck, the access completes with no write: regWeOut=0, wbData=0, stall=0. memFault is set and held until reset.
  - The FSM returns to IDLE.
- Undefined: no counter. WAIT lasts indefinitely and memFault is tied 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - DATA_W and REG_ADDR_W constants.
  - mem_state_t enum {IDLE, WAIT}.
  - struct wb_bundle_t {regWe, regToWrite, wbData}, also reused by the writeback stage.
- Optional sub-module: mem_wb_reg, the output pipeline register with a bubble-insert input.
- FSM, classification logic and timeout counter stay in memory_stage.

Test Plan:
- ALU passthrough: regWeIn=1, writeRegFromAluIn=1, regToWriteIn=2, resultIn=1 -> next edge regWeOut=1, regToWriteOut=2, wbData=1; memReq stays 0, stall=0.
- Zero-wait load: regWeIn=1, writeRegFromAluIn=0, regToWriteIn=3, resultIn=1, memAck=1 with memRdata=24'h00ABCD the same cycle -> memReq=1, memWrite=0, memAddr=1, stall=0; next edge wbData=24'h00ABCD, regToWriteOut=3.
- Store with 2 wait cycles: memWeIn=1, resultIn=3, dataToWriteIn=5; ack on the 3rd cycle -> memWrite=1, memAddr=3, memWdata=5 held 3 cycles, stall=1,1,0; regWeOut=0 throughout.
- Reset mid-WAIT: load pending, reset=1 for one cycle -> state IDLE, memReq=0, all registered outputs 0, memFault=0.
- Timeout, with MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=15: load, never ack -> stall drops after 15 WAIT cycles, memFault=1 and sticky, regWeOut=0. Without the macro: stall stays 1 for 100 cycles.
